io_buffer_arbiter: RTL

Shares one `io_buffer` LIFO between two requesters, such as a matrix loader and the sum engine. Each cycle it grants at most one push or pop, using round-robin between eligible requesters. It tracks occupancy so it never issues a push when full or a pop when empty. It routes pop data back to the requester whose pop was granted, and it provides a flush sequence that drains the buffer.

---
 rtl/io_buffer_pkg.sv | 11 +
 rtl/io_buffer_arbiter_rr.sv | 15 +
 rtl/io_buffer_arbiter.sv | 67 ++++++
 3 files changed

// File: rtl/io_buffer_pkg.sv
// io_buffer_pkg: shared op encodings, FSM states and sizing helper for the io_buffer arbiter
package io_buffer_pkg;
  localparam logic OP_POP  = 1'b0;
  localparam logic OP_PUSH = 1'b1;
  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction
endpackage

// File: rtl/io_buffer_arbiter_rr.sv
// rr_arbiter_2: two-input round-robin arbiter owning the priority pointer
module rr_arbiter_2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_elig,
  input  logic       i_accept,
  output logic [1:0] o_grant
);
  logic ptr;
  assign o_grant = &i_elig ? (ptr ? 2'b10 : 2'b01) : i_elig;
  // after a grant the other requester becomes preferred
  always_ff @(posedge i_clk)
    if (i_rst) ptr <= 1'b0;
    else if (i_accept) ptr <= o_grant[0];
endmodule

// File: rtl/io_buffer_arbiter.sv
// io_buffer_arbiter: shares one LIFO between two requesters with occupancy tracking and flush
module io_buffer_arbiter
  import io_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int STACK_SIZE = 256,
  localparam int CNT_WIDTH = clog2(STACK_SIZE + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [1:0]              i_req_valid,
  input  logic [1:0]              i_req_op,
  input  logic [2*DATA_WIDTH-1:0] i_req_data,
  output logic [1:0]              o_req_ready,
  output logic [1:0]              o_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_rsp_data,
  input  logic                    i_flush,
  output logic                    o_flush_done,
  output logic                    o_busy,
  output logic                    o_buf_push,
  output logic                    o_buf_pop,
  output logic [DATA_WIDTH-1:0]   o_buf_data,
  input  logic [DATA_WIDTH-1:0]   i_buf_data,
  output logic [CNT_WIDTH-1:0]    o_count,
  output logic                    o_full,
  output logic                    o_empty
);
  state_t st;
  logic idle;
  logic [1:0] elig, gnt, pop_gnt;
  assign idle = st == ST_IDLE;
  for (genvar g = 0; g < 2; g++) begin : g_elig
    assign elig[g] = i_req_valid[g] & idle & !i_rst & !i_flush &
                     (i_req_op[g] == OP_PUSH ? !o_full : !o_empty);
  end
  rr_arbiter_2 u_rr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_elig   (elig),
    .i_accept (|gnt),
    .o_grant  (gnt)
  );
  assign pop_gnt      = gnt & ~i_req_op;
  assign o_req_ready  = gnt;
  assign o_buf_push   = |(gnt & i_req_op);
  assign o_buf_pop    = |pop_gnt | (!idle & !i_rst & !o_empty);
  assign o_buf_data   = gnt[1] ? i_req_data[DATA_WIDTH +: DATA_WIDTH] : i_req_data[0 +: DATA_WIDTH];
  assign o_rsp_data   = i_buf_data;
  assign o_busy       = !idle;
  assign o_flush_done = !idle & o_empty;
  assign o_full       = o_count == CNT_WIDTH'(STACK_SIZE);
  assign o_empty      = o_count == '0;
  // occupancy follows every issued push or pop, including flush drains
  always_ff @(posedge i_clk)
    if (i_rst) o_count <= '0;
    else if (o_buf_push) o_count <= o_count + 1'b1;
    else if (o_buf_pop) o_count <= o_count - 1'b1;
  // IDLE/FLUSH control: leave FLUSH once the buffer is empty
  always_ff @(posedge i_clk)
    if (i_rst) st <= ST_IDLE;
    else if (idle && i_flush) st <= ST_FLUSH;
    else if (!idle && o_empty) st <= ST_IDLE;
  // pop response strobe lines up with the buffer's registered read data
  always_ff @(posedge i_clk)
    if (i_rst) o_rsp_valid <= 2'b00;
    else o_rsp_valid <= pop_gnt;
endmodule
